imem_loader: RTL and testbench

Program loader that writes the instruction memory of the single-cycle RV32I core. It accepts a byte stream containing a length header, little-endian instruction words and an XOR checksum. It assembles 32-bit words and issues one write per word on the instruction-RAM write port. While loading, it holds the core in reset through `core_hold`, and releases the core only after the checksum is verified.

---
 rtl/imem_loader_pkg.sv | 27 ++
 rtl/imem_loader_if.sv | 45 ++++
 rtl/imem_loader_word_packer.sv | 43 ++++
 rtl/imem_loader.sv | 170 +++++++++++++++++
 tb/tb_imem_loader.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Covers the state encoding, stream field widths and word geometry.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } loader_state_t;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_W     = 8;
  localparam int LEN_W      = 16;
  localparam int CSUM_W     = 8;
  localparam int WORD_W     = WORD_BYTES * BYTE_W;
  localparam int BCNT_W     = $clog2(WORD_BYTES);

  // States in which the loader is consuming stream bytes.
  function automatic logic is_stream_state(loader_state_t s);
    return s inside {ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream, instruction-RAM write port and core-control bundle.
// The loader uses the slave modport; the byte source/host uses master.
interface imem_loader_if #(
  parameter int ADDR_W = 12
);
  import loader_pkg::*;

  logic                load_req;
  logic                byte_valid;
  logic [BYTE_W-1:0]   byte_data;
  logic                byte_ready;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [WORD_W-1:0]   mem_wdata;
  logic                core_hold;
  logic                done;
  logic                error;

  modport master (
    output load_req,
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  core_hold,
    input  done,
    input  error
  );

  modport slave (
    input  load_req,
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output core_hold,
    output done,
    output error
  );

endinterface

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word assembler: byte k of a word lands in bits [8k+7:8k].
// word_o shows the completed word in the same cycle word_done_o is raised.
module word_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              byte_en_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_done_o
);

  logic [BCNT_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] asm_q, asm_d;

  always_comb begin
    cnt_d = cnt_q;
    asm_d = asm_q;
    if (clear_i) begin
      cnt_d = '0;
      asm_d = '0;
    end else if (byte_en_i) begin
      asm_d[cnt_q*BYTE_W +: BYTE_W] = byte_i;
      cnt_d = cnt_q + BCNT_W'(1);
    end
  end

  assign word_o      = asm_d;
  assign word_done_o = byte_en_i && !clear_i && (cnt_q == BCNT_W'(WORD_BYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads the RV32I instruction RAM from a length/data/XOR-checksum byte stream,
// holding the core in reset until the checksum has been verified.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus
);

  localparam logic [31:0] CAPACITY = 32'(1) << ADDR_W;

  loader_state_t       state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ADDR_W:0]     widx_q, widx_d;
  logic [CSUM_W-1:0]   xor_q, xor_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                hold_q, hold_d;

  logic                byte_ready;
  logic                fire;
  logic [LEN_W-1:0]    len_full;
  logic                pk_clear;
  logic                pk_en;
  logic [WORD_W-1:0]   pk_word;
  logic                pk_done;

  assign byte_ready = is_stream_state(state_q);
  assign fire       = bus.byte_valid && byte_ready;
  assign len_full   = {bus.byte_data, len_q[BYTE_W-1:0]};

  word_packer u_packer (
    .clk         (clk),
    .rst         (reset),
    .clear_i     (pk_clear),
    .byte_en_i   (pk_en),
    .byte_i      (bus.byte_data),
    .word_o      (pk_word),
    .word_done_o (pk_done)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    widx_d   = widx_q;
    xor_d    = xor_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done_d   = done_q;
    error_d  = error_q;
    hold_d   = hold_q;
    pk_clear = 1'b0;
    pk_en    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (bus.load_req) begin
          state_d  = ST_LEN0;
          len_d    = '0;
          widx_d   = '0;
          xor_d    = '0;
          done_d   = 1'b0;
          error_d  = 1'b0;
          hold_d   = 1'b1;
          pk_clear = 1'b1;
        end
      end

      ST_LEN0: begin
        if (fire) begin
          len_d[BYTE_W-1:0] = bus.byte_data;
          xor_d             = xor_q ^ bus.byte_data;
          state_d           = ST_LEN1;
        end
      end

      ST_LEN1: begin
        if (fire) begin
          len_d = len_full;
          xor_d = xor_q ^ bus.byte_data;
          if (32'(len_full) > CAPACITY) begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end else if (len_full == '0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (fire) begin
          xor_d = xor_q ^ bus.byte_data;
          pk_en = 1'b1;
          if (pk_done) begin
            we_d    = 1'b1;
            addr_d  = widx_q[ADDR_W-1:0];
            wdata_d = pk_word;
            widx_d  = widx_q + 1'b1;
            // Index is one bit wider than the address, so a full-capacity load ends cleanly.
            if (32'(widx_q) + 32'd1 == 32'(len_q)) begin
              state_d = ST_CSUM;
            end
          end
        end
      end

      ST_CSUM: begin
        if (fire) begin
          if (bus.byte_data == xor_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        hold_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      widx_q  <= '0;
      xor_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      xor_q   <= xor_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      error_q <= error_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.core_hold  = hold_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: fixed vector table, hand-built corner sequences and
// random streams checked against a stream-level reference model.
module tb_imem_loader;

  localparam int AW = 12;

  typedef struct packed {
    logic [0:11][7:0] s;
    logic [3:0]       len;
    logic [1:0]       gap;
    logic             exp_done;
    logic             exp_err;
    logic [1:0]       exp_nwr;
    logic [31:0]      w0;
    logic [31:0]      w1;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(AW)) bus ();
  imem_loader #(.ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0]      stim[$];
  logic [AW+31:0]  wr_q[$];
  logic [AW+31:0]  exp_wr[$];
  int              wr_cyc[$];
  logic            exp_done, exp_err;
  vec_t            tbl[7];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset === 1'b0 && bus.mem_we === 1'b1) begin
      wr_q.push_back({bus.mem_addr, bus.mem_wdata});
      wr_cyc.push_back(cyc);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(logic [0:11][7:0] s, int len, int gap, logic d, logic e,
                              int nwr, logic [31:0] w0, logic [31:0] w1);
    vec_t v;
    v.s = s; v.len = 4'(len); v.gap = 2'(gap); v.exp_done = d; v.exp_err = e;
    v.exp_nwr = 2'(nwr); v.w0 = w0; v.w1 = w1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle_gap(input int n);
    bus.byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (bus.byte_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (bus.byte_ready !== 1'b1) chk("byte_accept_timeout", 64'(bus.byte_ready), 64'd1);
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic start_load();
    wr_q.delete();
    wr_cyc.delete();
    bus.load_req = 1'b1;
    @(negedge clk);
    bus.load_req = 1'b0;
    chk("start_byte_ready", 64'(bus.byte_ready), 64'd1);
    chk("start_done_clr",   64'(bus.done),       64'd0);
    chk("start_error_clr",  64'(bus.error),      64'd0);
    chk("start_core_hold",  64'(bus.core_hold),  64'd1);
  endtask

  task automatic drive_stream(input int min_gap, input int max_gap, input int req_at);
    for (int i = 0; i < stim.size(); i++) begin
      if (max_gap > 0) idle_gap(int'($urandom_range(max_gap, min_gap)));
      if (i == req_at) begin
        bus.byte_valid = 1'b0;
        bus.load_req   = 1'b1;
        @(negedge clk);
        bus.load_req   = 1'b0;
      end
      send_byte(stim[i]);
    end
  endtask

  task automatic check_outcome(input string nm, input logic d, input logic e, input int nwr);
    chk({nm, "_done"},       64'(bus.done),       64'(d));
    chk({nm, "_error"},      64'(bus.error),      64'(e));
    chk({nm, "_core_hold"},  64'(bus.core_hold),  64'(!d));
    chk({nm, "_byte_ready"}, 64'(bus.byte_ready), 64'd0);
    chk({nm, "_nwrites"},    64'(wr_q.size()),    64'(nwr));
  endtask

  // Reference: parse the stream by its format rules, no notion of states or counters.
  task automatic model_run();
    int n;
    logic [7:0] x;
    exp_wr.delete();
    n = int'({stim[1], stim[0]});
    if (n > (1 << AW)) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < stim.size() - 1; i++) x ^= stim[i];
    for (int w = 0; w < n; w++)
      exp_wr.push_back({AW'(w), stim[2+4*w+3], stim[2+4*w+2], stim[2+4*w+1], stim[2+4*w]});
    exp_done = (stim[stim.size()-1] == x);
    exp_err  = !exp_done;
  endtask

  task automatic compare_writes(input string nm);
    chk({nm, "_wr_count"}, 64'(wr_q.size()), 64'(exp_wr.size()));
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++)
      chk({nm, "_wr"}, 64'(wr_q[i]), 64'(exp_wr[i]));
  endtask

  task automatic load_tbl(input int t);
    stim.delete();
    for (int j = 0; j < int'(tbl[t].len); j++) stim.push_back(tbl[t].s[j]);
  endtask

  task automatic build_random(input int n, input logic corrupt);
    logic [7:0] x;
    stim.delete();
    stim.push_back(8'(n));
    stim.push_back(8'(n >> 8));
    if (n <= (1 << AW)) begin
      for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
      x = 8'h00;
      foreach (stim[i]) x ^= stim[i];
      if (corrupt) x ^= 8'($urandom_range(255, 1));
      stim.push_back(x);
    end
  endtask

  initial begin
    int n, req_at;
    tbl[0] = mk({8'h02,8'h00,8'h13,8'h05,8'h10,8'h00,8'h93,8'h05,8'h20,8'h00,8'hB2,8'h00},
                11, 0, 1'b1, 1'b0, 2, 32'h00100513, 32'h00200593);
    tbl[1] = mk({8'h00,8'h00,8'h00,72'h0}, 3, 0, 1'b1, 1'b0, 0, 32'h0, 32'h0);
    tbl[2] = mk({8'h02,8'h00,8'h13,8'h05,8'h10,8'h00,8'h93,8'h05,8'h20,8'h00,8'hB3,8'h00},
                11, 0, 1'b0, 1'b1, 2, 32'h00100513, 32'h00200593);
    tbl[3] = mk({8'h01,8'h10,80'h0}, 2, 0, 1'b0, 1'b1, 0, 32'h0, 32'h0);
    tbl[4] = mk({8'h01,8'h00,8'hEF,8'hBE,8'hAD,8'hDE,8'h23,40'h0},
                7, 0, 1'b1, 1'b0, 1, 32'hDEADBEEF, 32'h0);
    tbl[5] = mk({8'h00,8'h00,8'h01,72'h0}, 3, 0, 1'b0, 1'b1, 0, 32'h0, 32'h0);
    tbl[6] = mk({8'h02,8'h00,8'h13,8'h05,8'h10,8'h00,8'h93,8'h05,8'h20,8'h00,8'hB2,8'h00},
                11, 3, 1'b1, 1'b0, 2, 32'h00100513, 32'h00200593);

    reset = 1'b1;
    bus.load_req = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_byte_ready", 64'(bus.byte_ready), 64'd0);
    chk("rst_mem_we",     64'(bus.mem_we),     64'd0);
    chk("rst_mem_addr",   64'(bus.mem_addr),   64'd0);
    chk("rst_mem_wdata",  64'(bus.mem_wdata),  64'd0);
    chk("rst_done",       64'(bus.done),       64'd0);
    chk("rst_error",      64'(bus.error),      64'd0);
    chk("rst_core_hold",  64'(bus.core_hold),  64'd1);
    reset = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data = 8'h55;
    repeat (2) @(negedge clk);
    chk("idle_ignores_bytes", 64'(bus.byte_ready), 64'd0);
    bus.byte_valid = 1'b0;

    // Vector table
    for (int t = 0; t < 7; t++) begin
      load_tbl(t);
      start_load();
      drive_stream((tbl[t].gap != 2'd0) ? 1 : 0, int'(tbl[t].gap), -1);
      check_outcome("tbl", tbl[t].exp_done, tbl[t].exp_err, int'(tbl[t].exp_nwr));
      if (tbl[t].exp_nwr >= 2'd1 && wr_q.size() >= 1)
        chk("tbl_w0", 64'(wr_q[0]), 64'({AW'(0), tbl[t].w0}));
      if (tbl[t].exp_nwr >= 2'd2 && wr_q.size() >= 2)
        chk("tbl_w1", 64'(wr_q[1]), 64'({AW'(1), tbl[t].w1}));
    end

    // Back-to-back two-word load: pulse timing, held address/data, CSUM readiness
    load_tbl(0);
    start_load();
    for (int i = 0; i < 10; i++) send_byte(stim[i]);
    chk("b2b_last_we",       64'(bus.mem_we),     64'd1);
    chk("b2b_csum_ready",    64'(bus.byte_ready), 64'd1);
    chk("b2b_last_addr",     64'(bus.mem_addr),   64'd1);
    chk("b2b_last_wdata",    64'(bus.mem_wdata),  64'h00200593);
    send_byte(stim[10]);
    chk("b2b_done",          64'(bus.done),       64'd1);
    chk("b2b_core_hold",     64'(bus.core_hold),  64'd0);
    chk("b2b_we_low",        64'(bus.mem_we),     64'd0);
    chk("b2b_addr_held",     64'(bus.mem_addr),   64'd1);
    chk("b2b_wdata_held",    64'(bus.mem_wdata),  64'h00200593);
    chk("b2b_spacing", (wr_cyc.size() == 2) ? 64'(wr_cyc[1] - wr_cyc[0]) : 64'hFFFF, 64'd4);

    // Backpressure with a load_req in the middle of DATA
    load_tbl(0);
    model_run();
    start_load();
    drive_stream(1, 3, 5);
    check_outcome("bp", 1'b1, 1'b0, 2);
    compare_writes("bp");

    // Reset after the 6th byte, then a fresh load
    load_tbl(0);
    start_load();
    for (int i = 0; i < 6; i++) send_byte(stim[i]);
    reset = 1'b1;
    #1;
    chk("midrst_byte_ready", 64'(bus.byte_ready), 64'd0);
    chk("midrst_mem_we",     64'(bus.mem_we),     64'd0);
    chk("midrst_mem_addr",   64'(bus.mem_addr),   64'd0);
    chk("midrst_mem_wdata",  64'(bus.mem_wdata),  64'd0);
    chk("midrst_done",       64'(bus.done),       64'd0);
    chk("midrst_error",      64'(bus.error),      64'd0);
    chk("midrst_core_hold",  64'(bus.core_hold),  64'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    model_run();
    start_load();
    drive_stream(0, 0, -1);
    check_outcome("postrst", 1'b1, 1'b0, 2);
    compare_writes("postrst");

    // Random streams against the reference model
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(9, 0) == 0) n = int'($urandom_range(65535, 4097));
      else n = int'($urandom_range(6, 0));
      build_random(n, $urandom_range(3, 0) == 0);
      model_run();
      req_at = (n > 0 && n <= (1 << AW)) ? int'($urandom_range(stim.size() - 2, 2)) : -1;
      start_load();
      drive_stream(0, 2, req_at);
      check_outcome("rnd", exp_done, exp_err, exp_wr.size());
      compare_writes("rnd");
    end

    // Full-capacity load: last word lands at the top address without wrapping
    build_random(1 << AW, 1'b0);
    model_run();
    start_load();
    drive_stream(0, 0, -1);
    check_outcome("full", 1'b1, 1'b0, 1 << AW);
    compare_writes("full");
    chk("full_last_addr", 64'(bus.mem_addr), 64'((1 << AW) - 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
